// File: rtl/multi_output_fifo.sv
// Circular-buffer FIFO with one push port and NUM_OUTPUT in-order pop slots.
// Slot k shows the k-th oldest entry; a cycle pops the leading run of ready slots.
module multi_output_fifo #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned NUM_OUTPUT = 4,
    parameter int unsigned BW         = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_valid,
    output logic                                i_ready,
    input  logic [BW-1:0]                       i_data,
    output logic [NUM_OUTPUT-1:0]               o_valid,
    input  logic [NUM_OUTPUT-1:0]               o_ready,
    output logic [NUM_OUTPUT-1:0][BW-1:0]       o_data,
    input  logic                                i_flush,
    output logic [$clog2(DEPTH):0]              o_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [BW-1:0] mem_q [DEPTH];
    logic [BW-1:0] mem_d [DEPTH];

    logic          push;
    logic          run;
    logic [CW-1:0] pops;

    // Handshake and slot view; flush masks both sides in the same cycle
    always_comb begin
        i_ready = (count_q < CW'(DEPTH)) && !i_flush;
        o_count = count_q;
        for (int k = 0; k < int'(NUM_OUTPUT); k++) begin
            o_valid[k] = (CW'(k) < count_q) && !i_flush;
            o_data[k]  = mem_q[head_q + PW'(k)];
        end
    end

    // Pops = length of the leading run of taken slots starting at slot 0
    always_comb begin
        push = i_valid && i_ready;
        pops = '0;
        run  = 1'b1;
        for (int k = 0; k < int'(NUM_OUTPUT); k++) begin
            if (run && o_valid[k] && o_ready[k]) begin
                pops = pops + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = i_data;
                tail_d        = tail_q + PW'(1);
            end
            head_d  = head_q + PW'(pops);
            count_d = count_q + CW'(push) - pops;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_multi_output_fifo.sv
// Directed self-checking bench for multi_output_fifo (DEPTH=8, NUM_OUTPUT=4, BW=8).
module tb_multi_output_fifo;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_valid;
    logic            i_ready;
    logic [7:0]      i_data;
    logic [3:0]      o_valid;
    logic [3:0]      o_ready;
    logic [3:0][7:0] o_data;
    logic            i_flush;
    logic [3:0]      o_count;

    int total = 0;
    int bad   = 0;

    multi_output_fifo #(.DEPTH(8), .NUM_OUTPUT(4), .BW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .i_flush (i_flush),
        .o_count (o_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_next;
        int pushed;
        int model_cnt;
        int cyc;
        int npop;

        rst = 1'b1; i_valid = 1'b0; i_data = '0; o_ready = '0; i_flush = 1'b0;
        #2;
        chk("rst_count", 32'(o_count), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_ready", 32'(i_ready), 1);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Fill to full with no consumer
        for (int i = 0; i < 8; i++) begin
            i_valid = 1'b1; i_data = 8'(8'h10 + i);
            #1 chk("fill_ready", 32'(i_ready), 1);
            tick();
            if (i == 0) chk("latency_slot0", 32'(o_valid), 32'h1);
        end
        i_valid = 1'b0;
        #1;
        chk("full_count", 32'(o_count), 8);
        chk("full_ready", 32'(i_ready), 0);
        chk("full_valid", 32'(o_valid), 32'hF);
        chk("full_d0", 32'(o_data[0]), 32'h10);
        chk("full_d1", 32'(o_data[1]), 32'h11);
        chk("full_d2", 32'(o_data[2]), 32'h12);
        chk("full_d3", 32'(o_data[3]), 32'h13);

        // Partial ready 1011 pops two; the push while full must be dropped
        o_ready = 4'b1011; i_valid = 1'b1; i_data = 8'hEE;
        tick();
        i_valid = 1'b0; o_ready = 4'b0000;
        #1;
        chk("part_count", 32'(o_count), 6);
        chk("part_d0", 32'(o_data[0]), 32'h12);
        chk("part_d3", 32'(o_data[3]), 32'h15);

        // Drain: 4 then 2
        o_ready = 4'b1111;
        tick();
        #1;
        chk("drain_count", 32'(o_count), 2);
        chk("drain_valid", 32'(o_valid), 32'h3);
        chk("drain_d0", 32'(o_data[0]), 32'h16);
        chk("drain_d1", 32'(o_data[1]), 32'h17);
        tick();
        o_ready = 4'b0000;
        #1;
        chk("empty_count", 32'(o_count), 0);
        chk("empty_valid", 32'(o_valid), 0);

        // Simultaneous push and pop
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1; i_data = 8'(8'hA0 + i);
            tick();
        end
        i_data = 8'hA3; o_ready = 4'b0001;
        #1 chk("sim_pre_d0", 32'(o_data[0]), 32'hA0);
        tick();
        i_valid = 1'b0; o_ready = 4'b0000;
        #1;
        chk("sim_count", 32'(o_count), 3);
        chk("sim_d0", 32'(o_data[0]), 32'hA1);
        chk("sim_d1", 32'(o_data[1]), 32'hA2);
        chk("sim_d2", 32'(o_data[2]), 32'hA3);

        // Ready on slot 1 alone is ignored because slot 0 is not taken
        o_ready = 4'b0010;
        tick();
        o_ready = 4'b0000;
        #1;
        chk("gap_count", 32'(o_count), 3);
        chk("gap_d0", 32'(o_data[0]), 32'hA1);

        // Flush during a push
        for (int i = 0; i < 2; i++) begin
            i_valid = 1'b1; i_data = 8'(8'hB0 + i);
            tick();
        end
        i_valid = 1'b0;
        #1 chk("preflush_count", 32'(o_count), 5);
        i_flush = 1'b1; i_valid = 1'b1; i_data = 8'hCC; o_ready = 4'b1111;
        #1;
        chk("flush_ready", 32'(i_ready), 0);
        chk("flush_valid", 32'(o_valid), 0);
        tick();
        i_flush = 1'b0; i_valid = 1'b0; o_ready = 4'b0000;
        #1;
        chk("flush_count", 32'(o_count), 0);
        chk("flush_valid_after", 32'(o_valid), 0);
        i_valid = 1'b1; i_data = 8'h77;
        tick();
        i_valid = 1'b0;
        #1;
        chk("postflush_valid", 32'(o_valid), 32'h1);
        chk("postflush_d0", 32'(o_data[0]), 32'h77);
        o_ready = 4'b0001;
        tick();
        o_ready = 4'b0000;

        // Stream 20 entries across pointer wrap, popping up to 3 on even cycles
        exp_next = 0; pushed = 0; model_cnt = 0; cyc = 0;
        while (exp_next < 20 && cyc < 200) begin
            i_valid = (pushed < 20);
            i_data  = 8'(pushed);
            o_ready = (cyc % 2 == 0) ? 4'b0111 : 4'b0000;
            #1;
            npop = 0;
            for (int k = 0; k < 3; k++) begin
                if (o_ready[k] && o_valid[k] && npop == k) begin
                    chk("wrap_data", 32'(o_data[k]), 32'(exp_next));
                    exp_next++;
                    npop++;
                end
            end
            if (i_valid && i_ready) begin
                pushed++;
                model_cnt++;
            end
            model_cnt -= npop;
            tick();
            cyc++;
            chk("wrap_count", 32'(o_count), 32'(model_cnt));
        end
        i_valid = 1'b0; o_ready = 4'b0000;
        chk("wrap_done", 32'(exp_next), 20);
        chk("wrap_empty", 32'(o_count), 0);

        // Reset asynchronously mid-stream with a push in flight
        for (int i = 0; i < 6; i++) begin
            i_valid = 1'b1; i_data = 8'(8'hD0 + i);
            tick();
        end
        #1 chk("prerst_count", 32'(o_count), 6);
        #1 rst = 1'b1;
        #1;
        chk("arst_count", 32'(o_count), 0);
        chk("arst_valid", 32'(o_valid), 0);
        tick();
        i_valid = 1'b0;
        #1 rst = 1'b0;
        tick();
        i_valid = 1'b1; i_data = 8'h55;
        tick();
        i_valid = 1'b0;
        #1;
        chk("postrst_valid", 32'(o_valid), 32'h1);
        chk("postrst_d0", 32'(o_data[0]), 32'h55);
        chk("postrst_count", 32'(o_count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
